reg_alloc_unit: RTL and testbench
=================================

Name: reg_alloc_unit

Overview:
Parametrised successor to the operand-collector register allocation/mapping stage. Grants physical register-file blocks to hardware warps on launch and reclaims them on exit, using a per-warp block LUT and a free map. Performs combinational arch-to-physical (bank, row) translation for two source reads and one CDB writeback. Adds capacity checking with explicit reject, ready/valid handshakes, a free-block counter and a multi-cycle dealloc walk.

Parameters:
NUM_WARPS, 8, hardware warp slots (power of 2)
ARCH_REGS, 8, architectural registers per warp (power of 2)
NUM_BANKS, 4, physical RF banks (power of 2)
NUM_ROWS, 8, rows per bank (power of 2)
GRAN, 2, registers per allocation block; consecutive arch regs, one per bank (GRAN divides NUM_BANKS and ARCH_REGS)
Derived: BPW=ARCH_REGS/GRAN LUT entries per warp; GPR=NUM_BANKS/GRAN bank groups; NUM_BLOCKS=NUM_ROWS*GPR

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
alloc_valid  in  1  launch request
alloc_ready  out  1  request accepted this cycle when high with alloc_valid
alloc_warp  in  clog2(NUM_WARPS)  target warp
alloc_nblk  in  clog2(BPW+1)  blocks requested
alloc_done  out  1  one-cycle pulse, last block written
alloc_fail  out  1  one-cycle pulse, request rejected
exit_valid  in  1  warp-exit request
exit_ready  out  1  exit accepted
exit_warp  in  clog2(NUM_WARPS)  exiting warp
exit_done  out  1  one-cycle pulse, all blocks of warp freed
alloc_stall  out  NUM_WARPS  one-hot of warp currently in ALLOC, else 0
free_blocks  out  clog2(NUM_BLOCKS+1)  free block count
rd_warp  in  clog2(NUM_WARPS)  warp for source lookups
rd0_reg, rd1_reg  in  clog2(ARCH_REGS)  source arch regs
rd0_bank, rd1_bank  out  clog2(NUM_BANKS)  physical bank
rd0_row, rd1_row  out  clog2(NUM_ROWS)  physical row
rd0_mapped, rd1_mapped  out  1  LUT entry valid
rd_same_bank  out  1  rd0_bank==rd1_bank and both mapped
wr_warp  in  clog2(NUM_WARPS)  CDB writeback warp
wr_reg  in  clog2(ARCH_REGS)  writeback arch reg
wr_bank, wr_row, wr_mapped  out  as rd0  writeback translation

Behaviour:
- Reset (async, rst=0): FSM IDLE; all LUT valid bits 0; free map all free; free_blocks=NUM_BLOCKS; all pulses 0; alloc_stall=0. Reset mid-ALLOC/DEALLOC abandons the operation; no done pulse.
- FSM IDLE/ALLOC/DEALLOC. alloc_ready and exit_ready high only in IDLE; exit_ready=1, alloc_ready=!exit_valid (exit wins on simultaneous requests).
- IDLE, alloc accepted: reject (alloc_fail next cycle, stay IDLE) if alloc_nblk>free_blocks, alloc_nblk>BPW, or warp already holds any valid entry. alloc_nblk=0: alloc_done next cycle, no LUT change. Otherwise latch warp/count, entry ptr=0, go ALLOC.
- ALLOC: one block per cycle; pick lowest-index free block b; LUT[warp][ptr]={1,b}; mark b used; free_blocks-1; ptr+1. After count blocks: alloc_done pulse in cycle after final write, return IDLE. Latency = nblk+1 cycles from acceptance.
- IDLE, exit accepted: latch warp, ptr=0, go DEALLOC. Each cycle: if LUT[warp][ptr] valid, clear valid, free its block, free_blocks+1. After ptr=BPW-1, exit_done pulse next cycle, IDLE. Fixed latency BPW+1.
- Translation (combinational, any state): entry=reg/GRAN; b=LUT block; row=b/GPR; bank=(b%GPR)*GRAN+reg%GRAN. Unmapped entry: mapped=0, bank/row=0. Lookup of a warp mid-ALLOC sees entries written so far.
- free_blocks always equals popcount of free map.

Decomposition:
- Package rau_pkg: derived widths, FSM state enum, LUT entry struct {valid, block}.
- Sub-module rau_free_finder: priority encoder returning lowest free index + any_free; the only natural split.

Test Plan:
- Reset then alloc warp 2, nblk=3 -> alloc_stall=8'h04 for 3 cycles, blocks 0,1,2 mapped, free_blocks=13, alloc_done at cycle 4; rd_warp=2 rd0_reg=5 -> bank 1 row 1 (block 2).
- Alloc warp 0 nblk=4 then warp 1 nblk=4, exit warp 0, alloc warp 3 nblk=2 -> warp 3 gets blocks 0,1; free_blocks=10.
- Fill 16 blocks over 4 warps, request nblk=1 -> alloc_fail pulse, no LUT/free_blocks change; nblk=5 with BPW=4 -> alloc_fail.
- alloc_valid and exit_valid same cycle -> exit accepted, alloc_ready=0; alloc accepted after exit_done.
- rd0_reg=0, rd1_reg=2 of warp with blocks 0 and 2 -> banks 0 and 0, rd_same_bank=1; unmapped reg -> mapped=0.
- Assert rst mid-ALLOC (after 2 of 4) -> free_blocks=16, no alloc_done, all mapped=0.

Source files
------------

// File: rtl/rau_pkg.sv
// Shared configuration, derived widths and types for the register allocation unit.
// Editing the base localparams here re-sizes the whole unit.
package rau_pkg;

   localparam int unsigned NUM_WARPS  = 8;
   localparam int unsigned ARCH_REGS  = 8;
   localparam int unsigned NUM_BANKS  = 4;
   localparam int unsigned NUM_ROWS   = 8;
   localparam int unsigned GRAN       = 2;

   localparam int unsigned BPW        = ARCH_REGS / GRAN;
   localparam int unsigned GPR        = NUM_BANKS / GRAN;
   localparam int unsigned NUM_BLOCKS = NUM_ROWS * GPR;

   localparam int unsigned WARP_W = $clog2(NUM_WARPS);
   localparam int unsigned REG_W  = $clog2(ARCH_REGS);
   localparam int unsigned BANK_W = $clog2(NUM_BANKS);
   localparam int unsigned ROW_W  = $clog2(NUM_ROWS);
   localparam int unsigned BLK_W  = $clog2(NUM_BLOCKS);
   localparam int unsigned PTR_W  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned NBLK_W = $clog2(BPW + 1);
   localparam int unsigned CNT_W  = $clog2(NUM_BLOCKS + 1);

   typedef enum logic [1:0] {StIdle, StAlloc, StDealloc} state_e;

   typedef struct packed {
      logic             valid;
      logic [BLK_W-1:0] block;
   } lut_entry_t;

   typedef struct packed {
      logic              mapped;
      logic [BANK_W-1:0] bank;
      logic [ROW_W-1:0]  row;
   } xlate_t;

   function automatic logic [PTR_W-1:0] entry_of(input logic [REG_W-1:0] arch_reg);
      return PTR_W'(32'(arch_reg) / GRAN);
   endfunction

   // A block spans GRAN adjacent banks of one row; the reg offset picks the bank inside it.
   function automatic xlate_t xlate(input lut_entry_t ent, input logic [REG_W-1:0] arch_reg);
      xlate_t      x;
      int unsigned blk;
      int unsigned ar;
      blk = 32'(ent.block);
      ar  = 32'(arch_reg);
      x   = '0;
      if (ent.valid) begin
         x.mapped = 1'b1;
         x.bank   = BANK_W'((blk % GPR) * GRAN + (ar % GRAN));
         x.row    = ROW_W'(blk / GPR);
      end
      return x;
   endfunction

endpackage

// File: rtl/rau_free_finder.sv
// Priority encoder over the free map: lowest free block index plus an any-free flag.
module rau_free_finder
   import rau_pkg::*;
#(
   parameter int unsigned N = NUM_BLOCKS,
   parameter int unsigned W = BLK_W
) (
   input  logic [N-1:0] i_free,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_free[i]) o_idx = W'(i);
      end
   end

   assign o_any = |i_free;

endmodule

// File: rtl/reg_alloc_unit.sv
// Grants physical RF blocks to warps on launch, reclaims them on exit, and translates
// arch registers of any warp to (bank, row) for two source reads and one writeback.
module reg_alloc_unit
   import rau_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_alloc_valid,
   output logic                 o_alloc_ready,
   input  logic [WARP_W-1:0]    i_alloc_warp,
   input  logic [NBLK_W-1:0]    i_alloc_nblk,
   output logic                 o_alloc_done,
   output logic                 o_alloc_fail,
   input  logic                 i_exit_valid,
   output logic                 o_exit_ready,
   input  logic [WARP_W-1:0]    i_exit_warp,
   output logic                 o_exit_done,
   output logic [NUM_WARPS-1:0] o_alloc_stall,
   output logic [CNT_W-1:0]     o_free_blocks,
   input  logic [WARP_W-1:0]    i_rd_warp,
   input  logic [REG_W-1:0]     i_rd0_reg,
   input  logic [REG_W-1:0]     i_rd1_reg,
   output logic [BANK_W-1:0]    o_rd0_bank,
   output logic [BANK_W-1:0]    o_rd1_bank,
   output logic [ROW_W-1:0]     o_rd0_row,
   output logic [ROW_W-1:0]     o_rd1_row,
   output logic                 o_rd0_mapped,
   output logic                 o_rd1_mapped,
   output logic                 o_rd_same_bank,
   input  logic [WARP_W-1:0]    i_wr_warp,
   input  logic [REG_W-1:0]     i_wr_reg,
   output logic [BANK_W-1:0]    o_wr_bank,
   output logic [ROW_W-1:0]     o_wr_row,
   output logic                 o_wr_mapped
);

   state_e                r_state;
   lut_entry_t            r_lut [NUM_WARPS][BPW];
   logic [NUM_BLOCKS-1:0] r_free;
   logic [CNT_W-1:0]      r_free_cnt;
   logic [WARP_W-1:0]     r_warp;
   logic [PTR_W-1:0]      r_ptr;
   logic [NBLK_W-1:0]     r_left;
   logic                  r_alloc_done;
   logic                  r_alloc_fail;
   logic                  r_exit_done;

   logic                  w_idle;
   logic                  w_alloc_go;
   logic                  w_exit_go;
   logic                  w_warp_busy;
   logic                  w_reject;
   logic [BLK_W-1:0]      w_free_idx;
   logic                  w_free_any;
   lut_entry_t            w_dealloc_ent;
   xlate_t                w_rd0;
   xlate_t                w_rd1;
   xlate_t                w_wr;

   assign w_idle        = (r_state == StIdle);
   assign o_exit_ready  = w_idle;
   assign o_alloc_ready = w_idle && !i_exit_valid;
   assign w_exit_go     = i_exit_valid && w_idle;
   assign w_alloc_go    = i_alloc_valid && o_alloc_ready;

   always_comb begin
      w_warp_busy = 1'b0;
      for (int e = 0; e < BPW; e++) begin
         w_warp_busy = w_warp_busy | r_lut[i_alloc_warp][e].valid;
      end
   end

   assign w_reject = (32'(i_alloc_nblk) > 32'(r_free_cnt)) || (32'(i_alloc_nblk) > BPW)
                     || w_warp_busy;

   assign w_dealloc_ent = r_lut[r_warp][r_ptr];

   rau_free_finder #(
      .N (NUM_BLOCKS),
      .W (BLK_W)
   ) u_free_finder (
      .i_free (r_free),
      .o_idx  (w_free_idx),
      .o_any  (w_free_any)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         for (int w = 0; w < NUM_WARPS; w++) begin
            for (int e = 0; e < BPW; e++) begin
               r_lut[w][e] <= '0;
            end
         end
         r_free       <= '1;
         r_free_cnt   <= CNT_W'(NUM_BLOCKS);
         r_warp       <= '0;
         r_ptr        <= '0;
         r_left       <= '0;
         r_alloc_done <= 1'b0;
         r_alloc_fail <= 1'b0;
         r_exit_done  <= 1'b0;
      end else begin
         r_alloc_done <= 1'b0;
         r_alloc_fail <= 1'b0;
         r_exit_done  <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_exit_go) begin
                  r_warp  <= i_exit_warp;
                  r_ptr   <= '0;
                  r_state <= StDealloc;
               end else if (w_alloc_go) begin
                  if (w_reject) begin
                     r_alloc_fail <= 1'b1;
                  end else if (i_alloc_nblk == '0) begin
                     r_alloc_done <= 1'b1;
                  end else begin
                     r_warp  <= i_alloc_warp;
                     r_left  <= i_alloc_nblk;
                     r_ptr   <= '0;
                     r_state <= StAlloc;
                  end
               end
            end
            StAlloc: begin
               // Capacity was checked on acceptance, so a free block is always present here.
               if (w_free_any) begin
                  r_lut[r_warp][r_ptr] <= '{valid: 1'b1, block: w_free_idx};
                  r_free[w_free_idx]   <= 1'b0;
                  r_free_cnt           <= r_free_cnt - 1'b1;
               end
               r_ptr  <= r_ptr + 1'b1;
               r_left <= r_left - 1'b1;
               if (r_left == NBLK_W'(1)) begin
                  r_alloc_done <= 1'b1;
                  r_state      <= StIdle;
               end
            end
            StDealloc: begin
               if (w_dealloc_ent.valid) begin
                  r_lut[r_warp][r_ptr].valid  <= 1'b0;
                  r_free[w_dealloc_ent.block] <= 1'b1;
                  r_free_cnt                  <= r_free_cnt + 1'b1;
               end
               r_ptr <= r_ptr + 1'b1;
               if (r_ptr == PTR_W'(BPW - 1)) begin
                  r_exit_done <= 1'b1;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_comb begin
      o_alloc_stall = '0;
      if (r_state == StAlloc) o_alloc_stall[r_warp] = 1'b1;
   end

   assign o_alloc_done  = r_alloc_done;
   assign o_alloc_fail  = r_alloc_fail;
   assign o_exit_done   = r_exit_done;
   assign o_free_blocks = r_free_cnt;

   assign w_rd0 = xlate(r_lut[i_rd_warp][entry_of(i_rd0_reg)], i_rd0_reg);
   assign w_rd1 = xlate(r_lut[i_rd_warp][entry_of(i_rd1_reg)], i_rd1_reg);
   assign w_wr  = xlate(r_lut[i_wr_warp][entry_of(i_wr_reg)], i_wr_reg);

   assign o_rd0_bank     = w_rd0.bank;
   assign o_rd0_row      = w_rd0.row;
   assign o_rd0_mapped   = w_rd0.mapped;
   assign o_rd1_bank     = w_rd1.bank;
   assign o_rd1_row      = w_rd1.row;
   assign o_rd1_mapped   = w_rd1.mapped;
   assign o_rd_same_bank = w_rd0.mapped && w_rd1.mapped && (w_rd0.bank == w_rd1.bank);
   assign o_wr_bank      = w_wr.bank;
   assign o_wr_row       = w_wr.row;
   assign o_wr_mapped    = w_wr.mapped;

endmodule

// File: tb/tb_reg_alloc_unit.sv
// Directed plus randomized bench for reg_alloc_unit against a block-list reference model.
module tb_reg_alloc_unit;
   import rau_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 alloc_valid = 1'b0;
   logic                 alloc_ready;
   logic [WARP_W-1:0]    alloc_warp = '0;
   logic [NBLK_W-1:0]    alloc_nblk = '0;
   logic                 alloc_done;
   logic                 alloc_fail;
   logic                 exit_valid = 1'b0;
   logic                 exit_ready;
   logic [WARP_W-1:0]    exit_warp = '0;
   logic                 exit_done;
   logic [NUM_WARPS-1:0] alloc_stall;
   logic [CNT_W-1:0]     free_blocks;
   logic [WARP_W-1:0]    rd_warp = '0;
   logic [REG_W-1:0]     rd0_reg = '0;
   logic [REG_W-1:0]     rd1_reg = '0;
   logic [BANK_W-1:0]    rd0_bank;
   logic [BANK_W-1:0]    rd1_bank;
   logic [ROW_W-1:0]     rd0_row;
   logic [ROW_W-1:0]     rd1_row;
   logic                 rd0_mapped;
   logic                 rd1_mapped;
   logic                 rd_same_bank;
   logic [WARP_W-1:0]    wr_warp = '0;
   logic [REG_W-1:0]     wr_reg = '0;
   logic [BANK_W-1:0]    wr_bank;
   logic [ROW_W-1:0]     wr_row;
   logic                 wr_mapped;

   int total = 0;
   int bad   = 0;

   // Reference model: block id per (warp, LUT entry), -1 when unmapped.
   int m_blk  [NUM_WARPS][BPW];
   bit m_used [NUM_BLOCKS];

   reg_alloc_unit u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_alloc_valid  (alloc_valid),
      .o_alloc_ready  (alloc_ready),
      .i_alloc_warp   (alloc_warp),
      .i_alloc_nblk   (alloc_nblk),
      .o_alloc_done   (alloc_done),
      .o_alloc_fail   (alloc_fail),
      .i_exit_valid   (exit_valid),
      .o_exit_ready   (exit_ready),
      .i_exit_warp    (exit_warp),
      .o_exit_done    (exit_done),
      .o_alloc_stall  (alloc_stall),
      .o_free_blocks  (free_blocks),
      .i_rd_warp      (rd_warp),
      .i_rd0_reg      (rd0_reg),
      .i_rd1_reg      (rd1_reg),
      .o_rd0_bank     (rd0_bank),
      .o_rd1_bank     (rd1_bank),
      .o_rd0_row      (rd0_row),
      .o_rd1_row      (rd1_row),
      .o_rd0_mapped   (rd0_mapped),
      .o_rd1_mapped   (rd1_mapped),
      .o_rd_same_bank (rd_same_bank),
      .i_wr_warp      (wr_warp),
      .i_wr_reg       (wr_reg),
      .o_wr_bank      (wr_bank),
      .o_wr_row       (wr_row),
      .o_wr_mapped    (wr_mapped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic void m_reset();
      for (int w = 0; w < NUM_WARPS; w++)
         for (int e = 0; e < BPW; e++) m_blk[w][e] = -1;
      for (int b = 0; b < NUM_BLOCKS; b++) m_used[b] = 1'b0;
   endfunction

   function automatic int m_free();
      int n = 0;
      for (int b = 0; b < NUM_BLOCKS; b++) if (!m_used[b]) n++;
      return n;
   endfunction

   function automatic bit m_holds(input int w);
      for (int e = 0; e < BPW; e++) if (m_blk[w][e] >= 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_lowest_free();
      for (int b = 0; b < NUM_BLOCKS; b++) if (!m_used[b]) return b;
      return -1;
   endfunction

   function automatic void m_xlate(input int w, input int r, output bit mp, output int bank,
                                   output int row);
      int b;
      b    = m_blk[w][r / GRAN];
      mp   = (b >= 0);
      bank = mp ? (b % GPR) * GRAN + (r % GRAN) : 0;
      row  = mp ? b / GPR : 0;
   endfunction

   task automatic do_reset();
      alloc_valid = 1'b0;
      exit_valid  = 1'b0;
      rst_n       = 1'b0;
      m_reset();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic do_alloc(input int w, input int n);
      bit fail;
      int b;
      fail        = (n > m_free()) || (n > BPW) || m_holds(w);
      alloc_valid = 1'b1;
      alloc_warp  = WARP_W'(w);
      alloc_nblk  = NBLK_W'(n);
      #1;
      check("alloc_ready_idle", 32'(alloc_ready), 1);
      tick();
      alloc_valid = 1'b0;
      if (fail) begin
         check("alloc_fail_pulse", 32'(alloc_fail), 1);
         check("alloc_done_on_reject", 32'(alloc_done), 0);
         check("alloc_stall_on_reject", 32'(alloc_stall), 0);
      end else begin
         for (int k = 0; k < n; k++) begin
            check("alloc_stall_onehot", 32'(alloc_stall), 32'(1) << w);
            check("alloc_done_early", 32'(alloc_done), 0);
            b = m_lowest_free();
            m_used[b]   = 1'b1;
            m_blk[w][k] = b;
            tick();
         end
         check("alloc_done_pulse", 32'(alloc_done), 1);
         check("alloc_fail_on_grant", 32'(alloc_fail), 0);
         check("alloc_stall_after", 32'(alloc_stall), 0);
      end
      check("free_blocks_after_alloc", 32'(free_blocks), m_free());
      tick();
      check("alloc_pulses_one_cycle", 32'({alloc_done, alloc_fail}), 0);
   endtask

   task automatic do_exit(input int w, input bit with_alloc);
      exit_valid  = 1'b1;
      exit_warp   = WARP_W'(w);
      alloc_valid = with_alloc;
      alloc_warp  = WARP_W'((w + 1) % NUM_WARPS);
      alloc_nblk  = NBLK_W'(1);
      #1;
      check("exit_ready_idle", 32'(exit_ready), 1);
      check("alloc_ready_vs_exit", 32'(alloc_ready), 0);
      tick();
      exit_valid  = 1'b0;
      alloc_valid = 1'b0;
      for (int k = 0; k < BPW; k++) begin
         check("exit_done_early", 32'(exit_done), 0);
         check("busy_during_dealloc", 32'({alloc_ready, exit_ready}), 0);
         tick();
      end
      check("exit_done_pulse", 32'(exit_done), 1);
      check("no_alloc_side_effect", 32'({alloc_done, alloc_fail}), 0);
      for (int e = 0; e < BPW; e++) begin
         if (m_blk[w][e] >= 0) m_used[m_blk[w][e]] = 1'b0;
         m_blk[w][e] = -1;
      end
      check("free_blocks_after_exit", 32'(free_blocks), m_free());
      tick();
      check("exit_done_one_cycle", 32'(exit_done), 0);
   endtask

   task automatic chk_xlate(input int w, input int r0, input int r1);
      bit m0, m1;
      int b0, b1, w0, w1;
      rd_warp = WARP_W'(w);
      rd0_reg = REG_W'(r0);
      rd1_reg = REG_W'(r1);
      wr_warp = WARP_W'(w);
      wr_reg  = REG_W'(r1);
      #1;
      m_xlate(w, r0, m0, b0, w0);
      m_xlate(w, r1, m1, b1, w1);
      check("rd0_mapped", 32'(rd0_mapped), 32'(m0));
      check("rd0_bank", 32'(rd0_bank), b0);
      check("rd0_row", 32'(rd0_row), w0);
      check("rd1_mapped", 32'(rd1_mapped), 32'(m1));
      check("rd1_bank", 32'(rd1_bank), b1);
      check("rd1_row", 32'(rd1_row), w1);
      check("rd_same_bank", 32'(rd_same_bank), 32'(m0 && m1 && (b0 == b1)));
      check("wr_mapped", 32'(wr_mapped), 32'(m1));
      check("wr_bank", 32'(wr_bank), b1);
      check("wr_row", 32'(wr_row), w1);
   endtask

   initial begin
      m_reset();
      @(negedge clk);
      #1;
      check("reset_free_blocks", 32'(free_blocks), NUM_BLOCKS);
      check("reset_stall", 32'(alloc_stall), 0);
      check("reset_pulses", 32'({alloc_done, alloc_fail, exit_done}), 0);
      check("reset_rd0_mapped", 32'(rd0_mapped), 0);
      do_reset();
      check("reset_ready", 32'({alloc_ready, exit_ready}), 32'b11);

      // First grant and a translation into block 2 (bank 1, row 1).
      do_alloc(2, 3);
      check("first_free_blocks", 32'(free_blocks), 13);
      chk_xlate(2, 5, 0);
      check("warp2_reg5_bank", 32'(rd0_bank), 1);
      check("warp2_reg5_row", 32'(rd0_row), 1);

      // Reuse of freed blocks goes lowest-index first.
      do_exit(2, 1'b0);
      do_alloc(0, 4);
      do_alloc(1, 4);
      do_exit(0, 1'b0);
      do_alloc(3, 2);
      check("reuse_free_blocks", 32'(free_blocks), 10);
      chk_xlate(3, 0, 2);
      check("warp3_entry1_row", 32'(rd1_row), 0);
      check("warp3_entry1_bank", 32'(rd1_bank), 2);

      // Fill the file, then capacity / size / ownership rejects.
      do_alloc(0, 4);
      do_alloc(2, 4);
      do_alloc(4, 2);
      check("full_free_blocks", 32'(free_blocks), 0);
      do_alloc(5, 1);
      check("full_reject_keeps_count", 32'(free_blocks), 0);
      chk_xlate(5, 0, 1);
      do_alloc(1, 0);

      // Simultaneous exit and alloc: exit wins, alloc retried afterwards.
      do_exit(4, 1'b1);
      do_alloc(5, 1);
      chk_xlate(5, 0, 1);
      do_alloc(6, 5);

      // Warp with blocks 0 and 2: reg 0 and reg 2 collide on bank 0.
      do_reset();
      do_alloc(1, 1);
      do_alloc(2, 1);
      do_alloc(3, 1);
      do_exit(1, 1'b0);
      do_exit(3, 1'b0);
      do_alloc(4, 2);
      chk_xlate(4, 0, 2);
      check("bank_conflict_flag", 32'(rd_same_bank), 1);
      chk_xlate(4, 4, 7);
      check("unmapped_reg", 32'(rd0_mapped), 0);
      do_alloc(4, 1);
      do_alloc(0, 0);

      // Reset partway through a 4-block grant.
      do_reset();
      alloc_valid = 1'b1;
      alloc_warp  = WARP_W'(0);
      alloc_nblk  = NBLK_W'(4);
      tick();
      alloc_valid = 1'b0;
      rd_warp = WARP_W'(0);
      rd0_reg = REG_W'(0);
      rd1_reg = REG_W'(2);
      tick();
      check("mid_alloc_entry0_seen", 32'(rd0_mapped), 1);
      check("mid_alloc_entry1_pending", 32'(rd1_mapped), 0);
      check("mid_alloc_free", 32'(free_blocks), 15);
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_free_blocks", 32'(free_blocks), NUM_BLOCKS);
      check("abort_stall", 32'(alloc_stall), 0);
      check("abort_mapped", 32'({rd0_mapped, rd1_mapped}), 0);
      tick();
      rst_n = 1'b1;
      m_reset();
      for (int k = 0; k < 4; k++) begin
         tick();
         check("abort_no_done", 32'(alloc_done), 0);
      end
      check("abort_free_after", 32'(free_blocks), NUM_BLOCKS);

      // Randomized traffic against the model.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) != 0)
            do_alloc(int'($urandom_range(0, NUM_WARPS - 1)), int'($urandom_range(0, BPW + 1)));
         else
            do_exit(int'($urandom_range(0, NUM_WARPS - 1)), 1'($urandom_range(0, 1)));
         chk_xlate(int'($urandom_range(0, NUM_WARPS - 1)), int'($urandom_range(0, ARCH_REGS - 1)),
                   int'($urandom_range(0, ARCH_REGS - 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
